sobel_edge_packer: RTL and testbench

//  Downstream of the Sobel control stage. Consumes its gradient pixel stream (pixel + 1-cycle ready

---
 rtl/sobel_edge_packer_pkg.sv | 19 +
 rtl/sobel_edge_packer_if.sv | 27 ++
 rtl/sobel_edge_packer_fifo.sv | 59 +++++
 rtl/sobel_edge_packer.sv | 113 +++++++++++
 tb/tb_sobel_edge_packer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_edge_packer_pkg.sv
// rtl/sobel_edge_packer_pkg.sv - shared types and constants for the Sobel edge packer
// Contents: state_t (packer FSM states), PACK_W (flags per output byte),
//           fifo_entry_t (one queued output byte plus its frame-end marker).
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PACK_W = 8;

    typedef struct packed {
        logic              last;
        logic [PACK_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sobel_edge_packer_if.sv
// rtl/sobel_edge_packer_if.sv - gradient pixel strobe in, packed edge byte stream out
// Signals: px_rdy/in_px (pixel strobe + pixel), out_byte/out_last/out_valid/out_ready (byte stream).
// Modports: slave = packer side, master = pixel source / byte consumer side.
interface sobel_edge_packer_if
    import sobel_pkg::*;
#(
    parameter int PX_W = 8
) ();

    logic              px_rdy;
    logic [PX_W-1:0]   in_px;
    logic [PACK_W-1:0] out_byte;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  px_rdy, in_px, out_ready,
        output out_byte, out_last, out_valid
    );

    modport master (
        output px_rdy, in_px, out_ready,
        input  out_byte, out_last, out_valid
    );

endinterface

// File: rtl/sobel_edge_packer_fifo.sv
// rtl/sobel_edge_packer_fifo.sv - synchronous byte FIFO between the packer and the output stream
// Ports: clk_i, nreset_i (sync active-low), push_i/push_data_i (write), pop_i (read),
//        head_o (oldest entry, zero when empty), full_o, empty_o.
module edge_byte_fifo
    import sobel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    input  logic        push_i,
    input  fifo_entry_t push_data_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_en;
    logic          rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer addresses, so the push is still accepted.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sobel_edge_packer.sv
// rtl/sobel_edge_packer.sv - thresholds gradient pixels to edge flags and packs 8 per byte
// Ports: clk_i, nreset_i (sync active-low), start_i (frame enable), threshold_i, frame_px_i,
//        bus (sobel_edge_packer_if.slave: pixel strobe in, byte stream out),
//        overflow_o (sticky byte-drop flag), busy_o (RUN state).
module sobel_edge_packer
    import sobel_pkg::*;
#(
    parameter int PX_W       = 8,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             start_i,
    input  logic [PX_W-1:0]  threshold_i,
    input  logic [CNT_W-1:0] frame_px_i,
    sobel_edge_packer_if.slave bus,
    output logic             overflow_o,
    output logic             busy_o
);

    state_t            state_q;
    logic [PACK_W-1:0] pack_q;
    logic [2:0]        bit_cnt_q;
    logic [CNT_W-1:0]  px_cnt_q;
    logic [CNT_W-1:0]  frame_px_q;
    logic              overflow_q;

    logic              edge_bit;
    logic [CNT_W-1:0]  px_cnt_d;
    logic              final_px;
    logic [PACK_W-1:0] byte_d;
    logic              take_px;
    logic              push;
    logic              pop;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;

    assign edge_bit = (bus.in_px >= threshold_i);
    assign px_cnt_d = px_cnt_q + 1'b1;
    assign final_px = (px_cnt_d == frame_px_q);
    assign byte_d   = pack_q | (PACK_W'(edge_bit) << bit_cnt_q);

    // An abort (start_i low) in the same cycle as a strobe wins: nothing is pushed.
    assign take_px = (state_q == RUN) && start_i && bus.px_rdy;
    assign push    = take_px && ((bit_cnt_q == 3'd7) || final_px);
    assign pop     = bus.out_valid && bus.out_ready;

    assign push_entry.last = final_px;
    assign push_entry.data = byte_d;

    edge_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.out_byte  = head.data;
    assign bus.out_last  = head.last;
    assign bus.out_valid = !fifo_empty;
    assign overflow_o    = overflow_q;
    assign busy_o        = (state_q == RUN);

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q    <= IDLE;
            pack_q     <= '0;
            bit_cnt_q  <= '0;
            px_cnt_q   <= '0;
            frame_px_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) overflow_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        frame_px_q <= frame_px_i;
                        overflow_q <= 1'b0;
                        pack_q     <= '0;
                        bit_cnt_q  <= '0;
                        px_cnt_q   <= '0;
                        state_q    <= (frame_px_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        state_q <= IDLE;
                    end else if (bus.px_rdy) begin
                        px_cnt_q  <= px_cnt_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        pack_q    <= push ? '0 : byte_d;
                        if (final_px) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_edge_packer.sv
// tb/tb_sobel_edge_packer.sv - self-checking bench for sobel_edge_packer
module tb_sobel_edge_packer;
    import sobel_pkg::*;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [7:0]  thr;
    logic [15:0] frame_px;
    logic        overflow;
    logic        busy;

    always #5 clk = ~clk;

    sobel_edge_packer_if #(.PX_W(8)) bus ();

    sobel_edge_packer #(
        .PX_W       (8),
        .CNT_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .start_i     (start),
        .threshold_i (thr),
        .frame_px_i  (frame_px),
        .bus         (bus),
        .overflow_o  (overflow),
        .busy_o      (busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         m_px[$];
    int         m_thr[$];
    bit         rnd_ready = 1'b0;

    typedef struct {
        int         n;
        int         thr;
        int         mode;
        int         val;
        int         nbytes;
        logic [7:0] b0;
        logic [8:0] blast;
    } vec_t;

    vec_t tab[5];

    // Capture every accepted output byte as {last, byte}.
    always @(negedge clk) begin
        if (nreset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back({bus.out_last, bus.out_byte});
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_frame(input int n);
        frame_px = 16'(n);
        start    = 1'b1;
        got_q.delete();
        m_px.delete();
        m_thr.delete();
        step(1);
    endtask

    task automatic pixel(input int v, input int t, input int gap, input bit in_frame);
        bus.px_rdy = 1'b0;
        step(gap);
        bus.in_px  = 8'(v);
        thr        = 8'(t);
        bus.px_rdy = 1'b1;
        step(1);
        bus.px_rdy = 1'b0;
        if (in_frame) begin
            m_px.push_back(v);
            m_thr.push_back(t);
        end
    endtask

    task automatic end_frame();
        start = 1'b0;
        step(1);
        chk("busy_after_end", 32'(busy), 32'd0);
    endtask

    // Reference: pixel i lands in byte i/8 at bit i%8; the frame's final byte carries last.
    function automatic void build_expected();
        int n;
        int nb;
        n  = m_px.size();
        nb = (n + 7) / 8;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            logic [7:0] v;
            v = '0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = b * 8 + k;
                if (i < n && m_px[i] >= m_thr[i]) v[k] = 1'b1;
            end
            exp_q.push_back({(b == nb - 1), v});
        end
    endfunction

    task automatic wait_drain(input int nexp, input string name);
        int t;
        t = 0;
        while (got_q.size() < nexp && t < 300) begin
            step(1);
            t++;
        end
        if (got_q.size() < nexp) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, got_q.size(), nexp);
        end
        step(5);
    endtask

    task automatic compare_model(input string name);
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        tab[0] = '{16, 100, 0, 0,   2, 8'h55, 9'h155};
        tab[1] = '{11, 128, 1, 255, 2, 8'hFF, 9'h107};
        tab[2] = '{8,  0,   1, 0,   1, 8'hFF, 9'h1FF};
        tab[3] = '{1,  10,  1, 10,  1, 8'h01, 9'h101};
        tab[4] = '{9,  11,  1, 10,  2, 8'h00, 9'h100};

        nreset        = 1'b0;
        start         = 1'b0;
        thr           = '0;
        frame_px      = '0;
        bus.px_rdy    = 1'b0;
        bus.in_px     = '0;
        bus.out_ready = 1'b1;
        step(2);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        nreset = 1'b1;
        step(1);

        // Table-driven frames with known packed results.
        for (int v = 0; v < 5; v++) begin
            begin_frame(tab[v].n);
            chk($sformatf("t%0d_busy", v), 32'(busy), 32'd1);
            for (int i = 0; i < tab[v].n; i++)
                pixel(tab[v].mode == 1 ? tab[v].val : ((i % 2) ? 50 : 200), tab[v].thr, 0, 1'b1);
            chk($sformatf("t%0d_done", v), 32'(busy), 32'd0);
            pixel(255, 0, 0, 1'b0);
            pixel(255, 0, 1, 1'b0);
            wait_drain(tab[v].nbytes, $sformatf("t%0d", v));
            chk($sformatf("t%0d_count", v), 32'(got_q.size()), 32'(tab[v].nbytes));
            if (got_q.size() > 0) begin
                chk($sformatf("t%0d_b0", v), 32'(got_q[0][7:0]), 32'(tab[v].b0));
                chk($sformatf("t%0d_blast", v), 32'(got_q[got_q.size()-1]), 32'(tab[v].blast));
                for (int i = 0; i < got_q.size() - 1; i++)
                    chk($sformatf("t%0d_nolast%0d", v, i), 32'(got_q[i][8]), 32'd0);
            end
            chk($sformatf("t%0d_ovf", v), 32'(overflow), 32'd0);
            end_frame();
        end

        // Random frames, random thresholds, strobe gaps and consumer back-pressure.
        rnd_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 40);
            begin_frame(n);
            for (int i = 0; i < n; i++)
                pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2), 1'b1);
            build_expected();
            wait_drain(exp_q.size(), $sformatf("rnd%0d", f));
            compare_model($sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_ovf", f), 32'(overflow), 32'd0);
            end_frame();
        end
        rnd_ready = 1'b0;
        step(2);

        // Overflow: 6 bytes into a 4-deep FIFO with no consumer.
        bus.out_ready = 1'b0;
        begin_frame(48);
        for (int i = 0; i < 48; i++) pixel(255, 0, 0, 1'b1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_done", 32'(busy), 32'd0);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(20);
        chk("ovf_drained", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("ovf_byte%0d", i), 32'(got_q[i]), 32'h0FF);
        end_frame();
        chk("ovf_held_idle", 32'(overflow), 32'd1);
        begin_frame(8);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) pixel((i % 2) ? 255 : 0, 128, 0, 1'b1);
        build_expected();
        wait_drain(exp_q.size(), "post_ovf");
        compare_model("post_ovf");
        chk("post_ovf_byte", 32'(got_q.size() > 0 ? got_q[0] : 9'h0), 32'h1AA);
        end_frame();

        // Full FIFO with push and pop on the same edge.
        bus.out_ready = 1'b0;
        begin_frame(40);
        for (int i = 0; i < 39; i++) pixel($urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b1);
        chk("pp_valid_full", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        pixel($urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b1);
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        build_expected();
        wait_drain(exp_q.size(), "pp");
        compare_model("pp");
        chk("pp_no_ovf_end", 32'(overflow), 32'd0);
        end_frame();

        // Abort after 5 of 16 pixels, then a clean restart.
        begin_frame(16);
        for (int i = 0; i < 5; i++) pixel(255, 0, 0, 1'b1);
        start = 1'b0;
        step(1);
        chk("abort_idle", 32'(busy), 32'd0);
        step(10);
        chk("abort_nobytes", 32'(got_q.size()), 32'd0);
        begin_frame(8);
        for (int i = 0; i < 8; i++) pixel((i < 3) ? 0 : 255, 128, 0, 1'b1);
        build_expected();
        wait_drain(exp_q.size(), "restart");
        compare_model("restart");
        end_frame();

        // Reset mid-frame with two bytes queued.
        bus.out_ready = 1'b0;
        begin_frame(32);
        for (int i = 0; i < 16; i++) pixel(255, 0, 0, 1'b1);
        chk("mrst_queued", 32'(bus.out_valid), 32'd1);
        nreset = 1'b0;
        start  = 1'b0;
        step(1);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_byte", 32'(bus.out_byte), 32'd0);
        chk("mrst_last", 32'(bus.out_last), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        nreset = 1'b1;
        step(2);
        chk("mrst_still_empty", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
